// File: rtl/rat_timer_int.sv
// Programmable interval timer on a 4-port MCU I/O window: 16-bit terminal count, one-shot or reload,
// expiry flag and fixed-length registered interrupt pulse. Register reads are combinational on PORT_ID.
module rat_timer_int #(
  parameter logic [7:0] BASE_ID = 8'hB0,
  parameter int         INT_LEN = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INT
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIRE} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_int_cnt, w_int_cnt_nxt;
  logic [15:0] r_tc;
  logic [7:0]  r_ctrl;
  logic        r_exp;
  logic        r_int;

  logic [7:0]  w_off;
  logic        w_hit, w_wr;
  logic        w_wr_tcl, w_wr_tch, w_wr_ctrl, w_wr_stat;
  logic [15:0] w_tc_eff;
  logic        w_match, w_exp_set, w_en_clr, w_ie_nxt;

  // Subtraction keeps decoding correct for bases that are not 4-aligned.
  assign w_off     = PORT_ID - BASE_ID;
  assign w_hit     = (w_off < 8'd4);
  assign w_wr      = IO_STRB & w_hit;
  assign w_wr_tcl  = w_wr && (w_off[1:0] == 2'd0);
  assign w_wr_tch  = w_wr && (w_off[1:0] == 2'd1);
  assign w_wr_ctrl = w_wr && (w_off[1:0] == 2'd2);
  assign w_wr_stat = w_wr && (w_off[1:0] == 2'd3);

  assign w_tc_eff  = (r_tc == 16'd0) ? 16'd1 : r_tc;
  assign w_match   = (r_cnt == w_tc_eff);
  assign w_ie_nxt  = w_wr_ctrl ? OUT_PORT[2] : r_ctrl[2];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_int_cnt_nxt = r_int_cnt;
    w_exp_set     = 1'b0;
    w_en_clr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 16'd0;
        if (w_wr_ctrl && OUT_PORT[0]) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_match) begin
          w_state_nxt   = S_FIRE;
          w_exp_set     = 1'b1;
          w_int_cnt_nxt = 4'd0;
          w_cnt_nxt     = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_FIRE: begin
        // Reload keeps the period running through FIRE so expiries stay evenly spaced.
        if (r_ctrl[1] && w_match) begin
          w_exp_set     = 1'b1;
          w_int_cnt_nxt = 4'd0;
          w_cnt_nxt     = 16'd0;
        end else begin
          w_cnt_nxt = r_ctrl[1] ? r_cnt + 16'd1 : 16'd0;
          if (r_int_cnt == 4'(INT_LEN - 1)) begin
            w_state_nxt = r_ctrl[1] ? S_RUN : S_IDLE;
            w_en_clr    = ~r_ctrl[1];
          end else begin
            w_int_cnt_nxt = r_int_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_wr_ctrl && !OUT_PORT[0]) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 16'd0;
      w_exp_set   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_int_cnt <= 4'd0;
      r_tc      <= 16'h0000;
      r_ctrl    <= 8'h00;
      r_exp     <= 1'b0;
      r_int     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_int_cnt <= w_int_cnt_nxt;
      if (w_wr_tcl) r_tc[7:0]  <= OUT_PORT;
      if (w_wr_tch) r_tc[15:8] <= OUT_PORT;
      if (w_wr_ctrl)     r_ctrl    <= OUT_PORT;
      else if (w_en_clr) r_ctrl[0] <= 1'b0;
      // A simultaneous expiry beats a clear.
      if (w_exp_set)                    r_exp <= 1'b1;
      else if (w_wr_stat && OUT_PORT[0]) r_exp <= 1'b0;
      r_int <= (w_state_nxt == S_FIRE) && w_ie_nxt;
    end
  end

  always_comb begin
    IN_PORT = 8'h00;
    if (w_hit) begin
      case (w_off[1:0])
        2'd0:    IN_PORT = r_tc[7:0];
        2'd1:    IN_PORT = r_tc[15:8];
        2'd2:    IN_PORT = r_ctrl;
        default: IN_PORT = {6'b0, (r_state != S_IDLE), r_exp};
      endcase
    end
  end

  assign INT = r_int;

endmodule

// File: tb/tb_rat_timer_int.sv
// Directed bench for rat_timer_int: one-shot, reload, IE=0, TC=0, clear/expiry race,
// address decode and asynchronous reset, with hand-computed cycle-by-cycle expectations.
module tb_rat_timer_int;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;
  logic       INT;

  int n_cmp = 0;
  int n_err = 0;

  rat_timer_int #(.BASE_ID(8'hB0), .INT_LEN(4)) dut (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .INT(INT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called on a negedge; the write is captured at the following posedge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    PORT_ID  = a;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    @(negedge CLK);
    IO_STRB  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    PORT_ID = a;
    #1;
    check(tag, {8'h00, IN_PORT}, {8'h00, exp});
  endtask

  initial begin
    RESET = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_int", {15'd0, INT}, 16'd0);
    for (int a = 0; a < 4; a++) rd_chk("rst_reg", 8'hB0 + 8'(a), 8'h00);
    @(negedge CLK);
    RESET = 1'b1;

    // One-shot, TC=5, IE: EXP and INT at cycle 6, INT for 4 cycles, then idle.
    wr(8'hB0, 8'h05); wr(8'hB1, 8'h00); wr(8'hB2, 8'h05);
    for (int k = 0; k < 12; k++) begin
      PORT_ID = 8'hB3; #1;
      check("os_int", {15'd0, INT}, (k >= 6 && k <= 9) ? 16'd1 : 16'd0);
      check("os_stat", {8'h00, IN_PORT}, {14'd0, (k <= 9), (k >= 6)});
      @(negedge CLK);
    end
    rd_chk("os_ctrl", 8'hB2, 8'h04);

    // Reload TC=3 with INT_LEN=4: expiry every 4 cycles keeps INT high.
    wr(8'hB3, 8'h01);
    wr(8'hB0, 8'h03); wr(8'hB2, 8'h07);
    for (int k = 0; k < 16; k++) begin
      PORT_ID = 8'hB3; #1;
      check("rl3_int", {15'd0, INT}, (k >= 4) ? 16'd1 : 16'd0);
      check("rl3_stat", {8'h00, IN_PORT}, (k >= 4) ? 16'h0003 : 16'h0002);
      @(negedge CLK);
    end
    wr(8'hB2, 8'h00);
    check("stop_int", {15'd0, INT}, 16'd0);
    rd_chk("stop_stat", 8'hB3, 8'h01);

    // Reload TC=5: pulses of 4 every 6 cycles.
    wr(8'hB0, 8'h05); wr(8'hB2, 8'h07);
    for (int k = 0; k < 21; k++) begin
      #1;
      check("rl5_int", {15'd0, INT}, (k >= 6 && ((k - 6) % 6) < 4) ? 16'd1 : 16'd0);
      @(negedge CLK);
    end
    wr(8'hB2, 8'h00);

    // TC=0 behaves as TC=1: expiry 2 cycles after RUN entry.
    wr(8'hB0, 8'h00); wr(8'hB2, 8'h05);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tc0_int", {15'd0, INT}, (k >= 2) ? 16'd1 : 16'd0);
      @(negedge CLK);
    end
    wr(8'hB2, 8'h00);

    // IE=0: EXP sets, INT never rises.
    wr(8'hB3, 8'h01);
    wr(8'hB0, 8'h02); wr(8'hB2, 8'h01);
    for (int k = 0; k < 9; k++) begin
      #1;
      check("ie0_int", {15'd0, INT}, 16'd0);
      if (k == 3) rd_chk("ie0_stat_fire", 8'hB3, 8'h03);
      @(negedge CLK);
    end
    rd_chk("ie0_stat", 8'hB3, 8'h01);
    rd_chk("ie0_ctrl", 8'hB2, 8'h00);
    wr(8'hB3, 8'h01);
    rd_chk("ie0_clr", 8'hB3, 8'h00);

    // Clear written on the expiry edge: set wins.
    wr(8'hB0, 8'h03); wr(8'hB2, 8'h01);
    repeat (3) @(negedge CLK);
    wr(8'hB3, 8'h01);
    rd_chk("race_stat", 8'hB3, 8'h03);
    repeat (6) @(negedge CLK);
    rd_chk("race_idle", 8'hB3, 8'h01);

    // Out-of-range write is ignored and reads 0.
    wr(8'hB4, 8'hFF);
    rd_chk("oor_b4", 8'hB4, 8'h00);
    rd_chk("oor_af", 8'hAF, 8'h00);
    rd_chk("oor_tcl", 8'hB0, 8'h03);
    rd_chk("oor_tch", 8'hB1, 8'h00);
    rd_chk("oor_ctrl", 8'hB2, 8'h00);
    rd_chk("oor_stat", 8'hB3, 8'h01);

    // Reset in FIRE drops INT without a clock edge.
    wr(8'hB0, 8'h02); wr(8'hB2, 8'h05);
    repeat (4) @(negedge CLK);
    #1;
    check("fire_int", {15'd0, INT}, 16'd1);
    #1 RESET = 1'b0;
    #1;
    check("arst_int", {15'd0, INT}, 16'd0);
    for (int a = 0; a < 4; a++) rd_chk("arst_reg", 8'hB0 + 8'(a), 8'h00);
    PORT_ID = 8'hB0; OUT_PORT = 8'h55; IO_STRB = 1'b1;
    @(posedge CLK); #1;
    check("arst_wr", {8'h00, IN_PORT}, 16'h0000);
    @(negedge CLK);
    IO_STRB = 1'b0;
    RESET = 1'b1;
    wr(8'hB0, 8'h5A);
    rd_chk("first_wr", 8'hB0, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
